// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the predicate that selects ops which open a busy window.
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_MFHI  = 3'd6,
        MDU_MFLO  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 32x32 multiply and divide datapath for the MDU.
// Signed division runs on magnitudes and fixes signs afterwards.
module mdu_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [31:0] q_m;
    logic [31:0] r_m;
    logic        signed_op;
    logic        neg_q;
    logic        neg_r;

    always_comb begin
        signed_op = (op == MDU_DIV);
        prod_u    = {32'b0, A} * {32'b0, B};
        prod_s    = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        div0      = (B == '0) && ((op == MDU_DIV) || (op == MDU_DIVU));

        // 0x80000000 has no positive twin, but as an unsigned magnitude it
        // divides correctly and re-negates to itself, covering MIN / -1.
        mag_a = (signed_op && A[31]) ? -A : A;
        mag_b = (signed_op && B[31]) ? -B : B;
        div_b = (mag_b == '0) ? 32'd1 : mag_b;
        q_u   = mag_a / div_b;
        r_u   = mag_a % div_b;
        neg_q = signed_op && (A[31] ^ B[31]);
        neg_r = signed_op && A[31];
        q_m   = neg_q ? -q_u : q_u;
        r_m   = neg_r ? -r_u : r_u;

        case (mdu_op_e'(op))
            MDU_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MDU_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MDU_DIV, MDU_DIVU: begin
                res_hi = r_m;
                res_lo = q_m;
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: fixed-latency busy window, HI/LO
// registers, and the MDU stall term for the hazard unit.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_use_D,
    input  logic        kill,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    mdu_state_e  state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] res_hi_q;
    logic [31:0] res_lo_q;
    logic        div0_q;

    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        calc_div0;
    logic        start_md;

    mdu_calc u_calc (
        .op     (op),
        .A      (A),
        .B      (B),
        .res_hi (calc_hi),
        .res_lo (calc_lo),
        .div0   (calc_div0)
    );

    assign start_md = start && is_muldiv(op);
    assign busy     = (state_q == MDU_BUSY);
    assign stall_md = md_use_D && (busy || start_md);
    assign hi       = hi_q;
    assign lo       = lo_q;

    always_comb begin
        case (mdu_op_e'(op))
            MDU_MFHI: rd_data = hi_q;
            MDU_MFLO: rd_data = lo_q;
            default:  rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= MDU_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            div0_q   <= 1'b0;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (start && !kill) begin
                        if (start_md) begin
                            res_hi_q <= calc_hi;
                            res_lo_q <= calc_lo;
                            div0_q   <= calc_div0;
                            cnt_q    <= ((op == MDU_DIV) || (op == MDU_DIVU)) ?
                                        CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                            state_q  <= MDU_BUSY;
                        end else if (op == MDU_MTHI) begin
                            hi_q <= A;
                        end else if (op == MDU_MTLO) begin
                            lo_q <= A;
                        end
                    end
                end
                MDU_BUSY: begin
                    // Kill wins over a commit landing on the same edge.
                    if (kill) begin
                        state_q <= MDU_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CW'(1)) begin
                        if (!div0_q) begin
                            hi_q <= res_hi_q;
                            lo_q <= res_lo_q;
                        end
                        state_q <= MDU_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= MDU_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus queues expected HI/LO commits and
// MFHI/MFLO reads; a monitor pops them when the DUT presents a result.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int unsigned MULN = 5;
    localparam int unsigned DIVN = 10;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic [2:0]  op       = 3'd0;
    logic [31:0] A        = '0;
    logic [31:0] B        = '0;
    logic        md_use_D = 1'b0;
    logic        kill     = 1'b0;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int checks = 0;
    int errors = 0;

    logic [63:0] q_hilo[$];
    logic [31:0] q_rd[$];
    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;

    always #5 clk = ~clk;

    mdu_ctrl #(
        .MUL_CYCLES (MULN),
        .DIV_CYCLES (DIVN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .md_use_D (md_use_D),
        .kill     (kill),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo),
        .rd_data  (rd_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic bit is_div(input logic [2:0] o);
        return (o == MDU_DIV) || (o == MDU_DIVU);
    endfunction

    // Reference arithmetic on 64-bit integers; returns {HI, LO}.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            MDU_MULT:  return 64'(sa * sb);
            MDU_MULTU: return ua * ub;
            MDU_DIV: begin
                if (b == 0) return 64'd0;
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            MDU_DIVU: begin
                if (b == 0) return 64'd0;
                return {a % b, a / b};
            end
            default:   return 64'd0;
        endcase
    endfunction

    // Monitor: commits show up on the falling edge of busy, reads on MFHI/MFLO.
    initial begin
        logic        busy_prev;
        logic [63:0] e;
        logic [31:0] r;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy_prev = 1'b0;
            end else begin
                if (busy_prev && !busy) begin
                    if (q_hilo.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL commit_unexpected actual hi=0x%08h lo=0x%08h required none", hi, lo);
                    end else begin
                        e = q_hilo.pop_front();
                        check("commit_hi", hi, e[63:32]);
                        check("commit_lo", lo, e[31:0]);
                    end
                end
                if (start && ((op == MDU_MFHI) || (op == MDU_MFLO))) begin
                    if (q_rd.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rd_unexpected actual=0x%08h required none", rd_data);
                    end else begin
                        r = q_rd.pop_front();
                        check("rd_data", rd_data, r);
                    end
                end
                busy_prev = busy;
            end
        end
    end

    task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic use_d, input int kill_at, input bit poke);
        int          n;
        int          last;
        logic [63:0] r;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        n      = is_div(o) ? int'(DIVN) : int'(MULN);
        r      = ref_result(o, a, b);
        old_hi = ref_hi;
        old_lo = ref_lo;
        @(posedge clk); #1;
        start = 1'b1; op = o; A = a; B = b; md_use_D = use_d;
        if (kill_at > 0 || (is_div(o) && b == 0)) begin
            q_hilo.push_back({ref_hi, ref_lo});
        end else begin
            q_hilo.push_back(r);
            ref_hi = r[63:32];
            ref_lo = r[31:0];
        end
        @(negedge clk);
        check("start_busy", 32'(busy), 32'd0);
        check("start_stall", 32'(stall_md), 32'(use_d));
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom_range(0, 7));
        last = (kill_at > 0) ? kill_at : n;
        for (int k = 1; k <= last; k++) begin
            if (k == kill_at) kill = 1'b1;
            if (poke && k == 2) begin
                start = 1'b1; op = 3'($urandom_range(0, 5)); A = $urandom; B = $urandom;
            end
            @(negedge clk);
            check("window_busy", 32'(busy), 32'd1);
            check("window_stall", 32'(stall_md), 32'(use_d));
            check("window_hi_held", hi, old_hi);
            check("window_lo_held", lo, old_lo);
            @(posedge clk); #1;
            kill = 1'b0; start = 1'b0;
        end
        @(negedge clk);
        check("after_busy", 32'(busy), 32'd0);
        check("after_stall", 32'(stall_md), 32'd0);
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] a);
        @(posedge clk); #1;
        start = 1'b1; op = o; A = a; md_use_D = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        if (o == MDU_MTHI) ref_hi = a; else ref_lo = a;
        @(negedge clk);
        check("mt_hi", hi, ref_hi);
        check("mt_lo", lo, ref_lo);
    endtask

    task automatic mf(input logic [2:0] o);
        @(posedge clk); #1;
        start = 1'b1; op = o;
        q_rd.push_back((o == MDU_MFHI) ? ref_hi : ref_lo);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic kill_with_start();
        @(posedge clk); #1;
        start = 1'b1; kill = 1'b1; op = MDU_MULT; A = $urandom; B = $urandom; md_use_D = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        @(negedge clk);
        check("killstart_busy", 32'(busy), 32'd0);
        check("killstart_hi", hi, ref_hi);
        check("killstart_lo", lo, ref_lo);
    endtask

    task automatic reset_mid_busy();
        @(posedge clk); #1;
        start = 1'b1; op = MDU_MULTU; A = 32'h1234_5678; B = 32'h9ABC_DEF0; md_use_D = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(stall_md), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        ref_hi = '0;
        ref_lo = '0;
        @(negedge clk); #2;
        reset = 1'b1; md_use_D = 1'b0;
        mt(MDU_MTHI, 32'h0000_00AB);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;
        int          kat;

        #1 reset = 1'b0;
        op = MDU_MFHI;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_stall", 32'(stall_md), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_rd", rd_data, 32'd0);
        @(negedge clk); #2;
        reset = 1'b1;

        run_md(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 0, 1'b0);
        check("mult_plan_hi", hi, 32'hFFFF_FFFF);
        check("mult_plan_lo", lo, 32'hFFFF_FFFA);
        mt(MDU_MTLO, 32'h0000_1234);
        mf(MDU_MFLO);
        run_md(MDU_DIVU, 32'd100, 32'd7, 1'b0, 0, 1'b0);
        run_md(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0);
        mt(MDU_MTHI, 32'h11);
        mt(MDU_MTLO, 32'h22);
        run_md(MDU_DIV, 32'd5, 32'd0, 1'b1, 0, 1'b0);
        mf(MDU_MFHI);
        run_md(MDU_DIV, 32'd1000, 32'd3, 1'b1, 4, 1'b0);
        run_md(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        mf(MDU_MFLO);
        kill_with_start();
        run_md(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 1'b1);
        reset_mid_busy();

        for (int it = 0; it < 30; it++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5) begin
                o = 3'($urandom_range(0, 3));
                case ($urandom_range(0, 7))
                    0:       begin a = $urandom; b = 32'd0; end
                    1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                    2, 3:    begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                    default: begin a = $urandom; b = $urandom; end
                endcase
                kat = ($urandom_range(0, 4) == 0) ?
                      $urandom_range(1, is_div(o) ? DIVN : MULN) : 0;
                run_md(o, a, b, 1'($urandom_range(0, 1)), kat, 1'($urandom_range(0, 1)));
            end else if (sel <= 7) begin
                mt((sel == 6) ? MDU_MTHI : MDU_MTLO, $urandom);
            end else begin
                mf((sel == 8) ? MDU_MFHI : MDU_MFLO);
            end
        end

        repeat (3) @(negedge clk);
        check("hilo_queue_drained", 32'(q_hilo.size()), 32'd0);
        check("rd_queue_drained", 32'(q_rd.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
